// File: rtl/dac_phase_sequencer.sv
// N-channel phase sequencer with a built-in SPI shifter: each frame has 2*NCH slots (on-word, then off-word per channel).
// Latency: all outputs are registered; the first frame_start shows 1 cycle and the first sclk high 3 cycles after en is sampled.
// No backpressure: level writes are always accepted, and a started slot transfer always completes (en is sampled only at slot end).
module dac_phase_sequencer #(
  parameter int NCH      = 3,
  parameter int DW       = 16,
  parameter int CMD_CODE = 3,
  parameter int SLOT_DIV = 64
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   en_i,
  input  logic                   level_we_i,
  input  logic [$clog2(NCH)-1:0] level_ch_i,
  input  logic [DW-1:0]          level_din_i,
  output logic [NCH-1:0]         phase_o,
  output logic                   frame_start_o,
  output logic                   busy_o,
  output logic                   spi_sclk_o,
  output logic                   spi_sdo_o,
  output logic [NCH-1:0]         spi_sync_n_o
);

  // Word = command nibble, level, 4 pad bits. SLOT_DIV must be >= 2*WW+4.
  localparam int WW    = DW + 8;
  localparam int NSLOT = 2 * NCH;
  localparam int CW    = $clog2(NCH);
  localparam int SW    = $clog2(SLOT_DIV);
  localparam int LW    = $clog2(NSLOT);

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_RUN  = 1'b1;

  localparam logic [3:0]    CMD       = 4'(CMD_CODE);
  localparam logic [SW-1:0] SCNT_LAST = SW'(SLOT_DIV - 1);
  localparam logic [SW-1:0] BUSY_LAST = SW'(2 * WW + 2);
  localparam logic [SW-1:0] SYNC_LAST = SW'(2 * WW + 1);
  localparam logic [SW-1:0] SHFT_LAST = SW'(2 * WW);
  localparam logic [LW-1:0] SLOT_LAST = LW'(NSLOT - 1);
  localparam logic [LW-1:0] NCH_L     = LW'(NCH);

  logic [0:0]    state_q, state_d;
  logic [SW-1:0] scnt_q, scnt_d;
  logic [LW-1:0] slot_q, slot_d;
  logic [DW-1:0] shadow_q [NCH];
  logic [DW-1:0] active_q [NCH];
  logic [WW-1:0] shreg_q, shreg_d;

  logic [NCH-1:0] phase_q, phase_d;
  logic [NCH-1:0] sync_n_q, sync_n_d;
  logic           frame_q, frame_d;
  logic           busy_q, busy_d;
  logic           sclk_q, sclk_d;
  logic           sdo_q, sdo_d;

  logic          run_d;
  logic          on_slot_d;
  logic [LW-1:0] tgt_d;
  logic [CW-1:0] tgt_ch_d;
  logic [WW-1:0] word_d;

  // Next-state for the run/idle FSM and the slot/scnt counters; en only matters at slot end.
  always_comb begin
    state_d = state_q;
    scnt_d  = scnt_q;
    slot_d  = slot_q;
    case (state_q)
      ST_IDLE: begin
        if (en_i) begin
          state_d = ST_RUN;
          scnt_d  = '0;
          slot_d  = '0;
        end
      end
      default: begin
        if (scnt_q == SCNT_LAST) begin
          scnt_d = '0;
          if (!en_i) begin
            state_d = ST_IDLE;
            slot_d  = '0;
          end else begin
            slot_d = (slot_q == SLOT_LAST) ? '0 : slot_q + 1'b1;
          end
        end else begin
          scnt_d = scnt_q + 1'b1;
        end
      end
    endcase
  end

  // Outputs are computed from the next counter values so each registered output matches its scnt in the same cycle.
  always_comb begin
    run_d     = (state_d == ST_RUN);
    on_slot_d = (slot_d < NCH_L);
    tgt_d     = on_slot_d ? slot_d : slot_d - NCH_L;
    tgt_ch_d  = CW'(tgt_d);
    // active_q is already the new frame's copy by the time the word is loaded at scnt 1.
    word_d    = on_slot_d ? {CMD, active_q[tgt_ch_d], 4'h0} : {CMD, DW'(0), 4'h0};

    frame_d = run_d && (scnt_d == '0) && (slot_d == '0);
    busy_d  = run_d && (scnt_d <= BUSY_LAST);

    phase_d = phase_q;
    if (!run_d) begin
      phase_d = '0;
    end else if (scnt_d == '0) begin
      phase_d[tgt_ch_d] = on_slot_d;
    end

    sync_n_d = '1;
    if (run_d && (scnt_d != '0) && (scnt_d <= SYNC_LAST)) begin
      sync_n_d[tgt_ch_d] = 1'b0;
    end

    sclk_d = run_d && (scnt_d >= SW'(2)) && (scnt_d <= SHFT_LAST) && !scnt_d[0];

    // New bit on each odd scnt, held through the following sclk-high cycle.
    sdo_d   = sdo_q;
    shreg_d = shreg_q;
    if (!run_d || (scnt_d == '0) || (scnt_d > SHFT_LAST)) begin
      sdo_d = 1'b0;
    end else if (scnt_d == SW'(1)) begin
      sdo_d   = word_d[WW-1];
      shreg_d = {word_d[WW-2:0], 1'b0};
    end else if (scnt_d[0]) begin
      sdo_d   = shreg_q[WW-1];
      shreg_d = {shreg_q[WW-2:0], 1'b0};
    end
  end

  // Control, counter, shifter and output registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= ST_IDLE;
      scnt_q   <= '0;
      slot_q   <= '0;
      shreg_q  <= '0;
      phase_q  <= '0;
      sync_n_q <= '1;
      frame_q  <= 1'b0;
      busy_q   <= 1'b0;
      sclk_q   <= 1'b0;
      sdo_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      scnt_q   <= scnt_d;
      slot_q   <= slot_d;
      shreg_q  <= shreg_d;
      phase_q  <= phase_d;
      sync_n_q <= sync_n_d;
      frame_q  <= frame_d;
      busy_q   <= busy_d;
      sclk_q   <= sclk_d;
      sdo_q    <= sdo_d;
    end
  end

  // Shadow levels take writes any time; active levels snapshot the pre-edge shadow at each frame start.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int k = 0; k < NCH; k++) begin
        shadow_q[k] <= '0;
        active_q[k] <= '0;
      end
    end else begin
      if (level_we_i && (32'(level_ch_i) < NCH)) begin
        shadow_q[level_ch_i] <= level_din_i;
      end
      if (frame_d) begin
        active_q <= shadow_q;
      end
    end
  end

  assign phase_o       = phase_q;
  assign frame_start_o = frame_q;
  assign busy_o        = busy_q;
  assign spi_sclk_o    = sclk_q;
  assign spi_sdo_o     = sdo_q;
  assign spi_sync_n_o  = sync_n_q;

endmodule

// File: tb/tb_dac_phase_sequencer.sv
// Bench for dac_phase_sequencer: cycle-level behavioural model plus literal checks on captured SPI words.
module tb_dac_phase_sequencer;

  localparam int NCH   = 3;
  localparam int DW    = 16;
  localparam int SD    = 64;
  localparam int WW    = DW + 8;
  localparam int FRAME = 2 * NCH * SD;
  localparam logic [3:0] CMD = 4'd3;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic en = 1'b0;
  logic we = 1'b0;
  logic [1:0] lch = 2'd0;
  logic [DW-1:0] ldin = '0;
  logic [NCH-1:0] phase, sync_n;
  logic fs, busy, sclk, sdo;

  dac_phase_sequencer #(.NCH(NCH), .DW(DW), .CMD_CODE(3), .SLOT_DIV(SD)) dut (
    .clk(clk), .rst(rst), .en_i(en), .level_we_i(we), .level_ch_i(lch), .level_din_i(ldin),
    .phase_o(phase), .frame_start_o(fs), .busy_o(busy), .spi_sclk_o(sclk),
    .spi_sdo_o(sdo), .spi_sync_n_o(sync_n)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  // Behavioural model: run flag plus elapsed cycles since the run began.
  bit m_run = 1'b0;
  int m_t = 0;
  logic [DW-1:0] m_shadow [NCH];
  logic [DW-1:0] m_active [NCH];

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_run = 1'b0;
      m_t = 0;
      for (int k = 0; k < NCH; k++) begin
        m_shadow[k] = '0;
        m_active[k] = '0;
      end
    end else begin
      if (!m_run) begin
        if (en) begin
          m_run = 1'b1;
          m_t = 0;
          m_active = m_shadow;
        end
      end else if ((m_t % SD) == SD - 1 && !en) begin
        m_run = 1'b0;
      end else begin
        m_t++;
        if ((m_t % FRAME) == 0) m_active = m_shadow;
      end
      if (we && lch < NCH) m_shadow[lch] = ldin;
    end
  end

  function automatic int m_slot();
    return (m_t / SD) % (2 * NCH);
  endfunction

  function automatic int m_scnt();
    return m_t % SD;
  endfunction

  // Expected {phase, frame_start, busy, sclk, sdo, sync_n} for the current cycle.
  function automatic logic [9:0] expect_out();
    logic [NCH-1:0] ph = '0;
    logic [NCH-1:0] sy = '1;
    logic f = 1'b0, b = 1'b0, sc = 1'b0, sd = 1'b0;
    int scnt, slot;
    logic [1:0] ch;
    logic [WW-1:0] w;
    if (m_run) begin
      scnt = m_scnt();
      slot = m_slot();
      ch = 2'(slot % NCH);
      for (int k = 0; k < NCH; k++)
        if (slot >= k && slot < k + NCH) ph = ph | (NCH'(1) << k);
      f = ((m_t % FRAME) == 0);
      b = (scnt <= 2 * WW + 2);
      if (scnt >= 1 && scnt <= 2 * WW + 1) sy = ~(NCH'(1) << ch);
      sc = (scnt >= 2) && (scnt <= 2 * WW) && (scnt % 2 == 0);
      w = {CMD, (slot < NCH) ? m_active[ch] : DW'(0), 4'h0};
      if (scnt >= 1 && scnt <= 2 * WW) sd = 1'(w >> (WW - 1 - (scnt - 1) / 2));
    end
    return {ph, f, b, sc, sd, sy};
  endfunction

  task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // SPI capture: bits sampled on each sclk high, one word per sync_n window.
  logic [WW-1:0] cap = '0;
  int np = 0;
  int cur_ch = 0;
  logic prev_sclk = 1'b0;
  logic [NCH-1:0] prev_sync = '1;
  logic [WW-1:0] q_w[$];
  int q_c[$];
  int q_n[$];

  task automatic cyc();
    @(posedge clk);
    #2;
    cmp("outputs", 32'({phase, fs, busy, sclk, sdo, sync_n}), 32'(expect_out()));
    if (!rst) begin
      cap = '0; np = 0; prev_sclk = 1'b0; prev_sync = '1;
    end else begin
      if (!prev_sclk && sclk) begin
        cap = {cap[WW-2:0], sdo};
        np++;
      end
      for (int k = 0; k < NCH; k++) if (!sync_n[k]) cur_ch = k;
      if (prev_sync != '1 && sync_n == '1) begin
        q_w.push_back(cap); q_c.push_back(cur_ch); q_n.push_back(np);
        cap = '0; np = 0;
      end
      prev_sclk = sclk;
      prev_sync = sync_n;
    end
  endtask

  task automatic expect_word(input string name, input logic [WW-1:0] w, input int ch);
    for (int i = 0; i < 2000 && q_w.size() == 0; i++) cyc();
    if (q_w.size() == 0) begin
      cmp({name, "_timeout"}, 32'd0, 32'd1);
    end else begin
      cmp({name, "_word"}, 32'(q_w.pop_front()), 32'(w));
      cmp({name, "_ch"}, 32'(q_c.pop_front()), 32'(ch));
      cmp({name, "_pulses"}, 32'(q_n.pop_front()), 32'(WW));
    end
  endtask

  task automatic write_lvl(input logic [1:0] c, input logic [DW-1:0] d);
    we = 1'b1; lch = c; ldin = d;
    cyc();
    we = 1'b0;
  endtask

  logic [WW-1:0] t6_w [9];
  int t6_c [9];
  int n;

  initial begin
    // Reset state, then idle with en low.
    repeat (3) cyc();
    cmp("rst_phase", 32'(phase), 32'd0);
    cmp("rst_sync", 32'(sync_n), 32'h7);
    cmp("rst_sclk", 32'(sclk), 32'd0);
    cmp("rst_busy", 32'(busy), 32'd0);
    rst = 1'b1;
    repeat (5) cyc();
    cmp("idle_busy", 32'(busy), 32'd0);
    cmp("idle_fs", 32'(fs), 32'd0);

    // Basic frame with ch0=1234.
    write_lvl(2'd0, 16'h1234);
    write_lvl(2'd1, 16'h1111);
    write_lvl(2'd2, 16'h2222);
    en = 1'b1;
    cyc();
    cmp("fs_latency", 32'(fs), 32'd1);
    cmp("phase_slot0", 32'(phase), 32'h1);
    cyc();
    cmp("sync_slot0", 32'(sync_n), 32'h6);
    cmp("sclk_pre", 32'(sclk), 32'd0);
    cyc();
    cmp("sclk_first", 32'(sclk), 32'd1);
    expect_word("s0", 24'h312340, 0);
    expect_word("s1", 24'h311110, 1);

    // Level write during slot 2 only reaches the next frame.
    for (int i = 0; i < 200 && m_slot() != 2; i++) cyc();
    cmp("reach_slot2", 32'(m_slot()), 32'd2);
    write_lvl(2'd1, 16'hABCD);
    expect_word("s2", 24'h322220, 2);
    expect_word("s3", 24'h300000, 0);
    cmp("phase_slot3", 32'(phase), 32'h6);
    expect_word("s4", 24'h300000, 1);
    expect_word("s5", 24'h300000, 2);
    expect_word("f2s0", 24'h312340, 0);
    expect_word("f2s1", 24'h3ABCD0, 1);

    // Out-of-range channel write, then a write coinciding with the frame copy.
    write_lvl(2'd3, 16'hFFFF);
    for (int i = 0; i < 500 && (m_t % FRAME) != FRAME - 1; i++) cyc();
    q_w.delete(); q_c.delete(); q_n.delete();
    write_lvl(2'd2, 16'h7777);
    cmp("fs_on_write_edge", 32'(fs), 32'd1);
    t6_w = '{24'h312340, 24'h3ABCD0, 24'h322220, 24'h300000, 24'h300000, 24'h300000,
             24'h312340, 24'h3ABCD0, 24'h377770};
    t6_c = '{0, 1, 2, 0, 1, 2, 0, 1, 2};
    for (int i = 0; i < 9; i++) expect_word($sformatf("t6_%0d", i), t6_w[i], t6_c[i]);

    // Drop en mid-slot 4; slot completes, then idle.
    for (int i = 0; i < 800 && !(m_slot() == 4 && m_scnt() == 10); i++) cyc();
    q_w.delete(); q_c.delete(); q_n.delete();
    en = 1'b0;
    n = 0;
    while (n < 100 && m_run) begin cyc(); n++; end
    cmp("drop_cycles", 32'(n), 32'd54);
    cmp("drop_phase", 32'(phase), 32'd0);
    cmp("drop_busy", 32'(busy), 32'd0);
    expect_word("s4_final", 24'h300000, 1);
    cyc();
    en = 1'b1;
    cyc();
    cmp("fs_rerun", 32'(fs), 32'd1);

    // Asynchronous reset during bit 10 of a shift.
    for (int i = 0; i < 400 && !(m_run && m_scnt() == 21); i++) cyc();
    en = 1'b0;
    rst = 1'b0;
    #1;
    cmp("arst_sync", 32'(sync_n), 32'h7);
    cmp("arst_sclk", 32'(sclk), 32'd0);
    cmp("arst_busy", 32'(busy), 32'd0);
    cmp("arst_phase", 32'(phase), 32'd0);
    repeat (3) cyc();
    rst = 1'b1;
    write_lvl(2'd0, 16'h5A5A);
    q_w.delete(); q_c.delete(); q_n.delete();
    en = 1'b1;
    expect_word("after_rst", 24'h35A5A0, 0);

    // Random traffic against the model.
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(299) == 0) en = ~en;
      we = ($urandom_range(5) == 0);
      lch = 2'($urandom_range(3));
      ldin = 16'($urandom);
      cyc();
    end
    we = 1'b0;
    en = 1'b0;
    repeat (2 * SD) cyc();
    cmp("end_idle", 32'(busy), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
